// File: rtl/mul_pipe_pkg.sv
// -----------------------------------------------------------------------------
// vp_mul_pkg
//   Shared types and helpers for the mul_pipe multiplier slice.
//   - mul_mode_e     : operand signedness selector (11 behaves as 00)
//   - MUL_MAX_LIMBS  : upper bound on limbs per operand
//   - MUL_MIN_STAGES / MUL_MAX_STAGES : legal pipeline depth range
//   - num_limbs()    : ceil(width / limb_width)
// -----------------------------------------------------------------------------
package vp_mul_pkg;

    typedef enum logic [1:0] {
        MUL_UU  = 2'b00,
        MUL_SS  = 2'b01,
        MUL_SU  = 2'b10,
        MUL_RSV = 2'b11
    } mul_mode_e;

    localparam int MUL_MAX_LIMBS  = 3;
    localparam int MUL_MIN_STAGES = 2;
    localparam int MUL_MAX_STAGES = 4;

    function automatic int num_limbs(input int width, input int limb_width);
        return (width + limb_width - 1) / limb_width;
    endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// -----------------------------------------------------------------------------
// mul_pipe_if
//   Operand/result bus of mul_pipe.
//   Input side : valid_i, ready_o, opa_i, opb_i, mode_i, tag_i
//   Output side: valid_o, ready_i, res_o, tag_o
//
//   Handshake: an op is accepted on a rising edge where valid_i && ready_o;
//   a result is consumed on a rising edge where valid_o && ready_i. Once
//   valid_o is high, res_o/tag_o hold until consumed. A producer that sees
//   ready_o low keeps valid_i and its operands stable.
//
//   slave  : the multiplier side
//   master : the issue/consumer side (producer of ops, sink of results)
// -----------------------------------------------------------------------------
interface mul_pipe_if #(
    parameter int data_width_p = 64,
    parameter int tag_width_p  = 4
);
    logic                      valid_i;
    logic                      ready_o;
    logic [data_width_p-1:0]   opa_i;
    logic [data_width_p-1:0]   opb_i;
    logic [1:0]                mode_i;
    logic [tag_width_p-1:0]    tag_i;
    logic                      valid_o;
    logic                      ready_i;
    logic [2*data_width_p-1:0] res_o;
    logic [tag_width_p-1:0]    tag_o;

    modport slave (
        input  valid_i, opa_i, opb_i, mode_i, tag_i, ready_i,
        output ready_o, valid_o, res_o, tag_o
    );

    modport master (
        output valid_i, opa_i, opb_i, mode_i, tag_i, ready_i,
        input  ready_o, valid_o, res_o, tag_o
    );
endinterface

// File: rtl/mul_limb_pp.sv
// -----------------------------------------------------------------------------
// mul_limb_pp
//   Combinational front end of mul_pipe. Splits both operands into unsigned
//   limbs, forms every limb x limb partial product, and computes the sign
//   correction term.
//   Ports:
//     opa_i, opb_i : raw W-bit operands
//     mode_i       : signedness mode
//     pp_o[i][j]   : opa limb i * opb limb j (unsigned, 2*limb_width_p bits)
//     corr_o       : upper-half correction, to be added at weight 2^W
// -----------------------------------------------------------------------------
module mul_limb_pp
    import vp_mul_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int limb_width_p = 23,
    parameter int limbs_p      = num_limbs(data_width_p, limb_width_p)
) (
    input  logic [data_width_p-1:0]   opa_i,
    input  logic [data_width_p-1:0]   opb_i,
    input  mul_mode_e                 mode_i,
    output logic [2*limb_width_p-1:0] pp_o [limbs_p][limbs_p],
    output logic [data_width_p-1:0]   corr_o
);
    localparam int PAD_W = limbs_p * limb_width_p;
    localparam int PP_W  = 2 * limb_width_p;

    logic [PAD_W-1:0] a_pad;
    logic [PAD_W-1:0] b_pad;
    logic             a_neg;
    logic             b_neg;

    always_comb begin
        a_pad = '0;
        b_pad = '0;
        a_pad[data_width_p-1:0] = opa_i;
        b_pad[data_width_p-1:0] = opb_i;
        for (int i = 0; i < limbs_p; i++) begin
            for (int j = 0; j < limbs_p; j++) begin
                pp_o[i][j] = PP_W'(a_pad[i*limb_width_p +: limb_width_p])
                           * PP_W'(b_pad[j*limb_width_p +: limb_width_p]);
            end
        end
    end

    // A signed operand x equals x_u - x[W-1]*2^W. Expanding the product, the
    // cross terms subtract the other (unsigned-read) operand at weight 2^W;
    // the 2^(2W) term vanishes modulo 2^(2W), so only W bits are needed.
    assign a_neg  = opa_i[data_width_p-1] & ((mode_i == MUL_SS) || (mode_i == MUL_SU));
    assign b_neg  = opb_i[data_width_p-1] & (mode_i == MUL_SS);
    assign corr_o = '0 - (a_neg ? opb_i : '0) - (b_neg ? opa_i : '0);

endmodule

// File: rtl/mul_pipe.sv
// -----------------------------------------------------------------------------
// mul_pipe
//   Fully pipelined W x W -> 2W multiplier (unsigned, signed, signed x
//   unsigned) with a per-op tag and whole-pipe stall on backpressure.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_n   : asynchronous active-low reset
//     flush_i : (VP_MUL_FLUSH_EN only) synchronous flush of all in-flight ops
//     bus     : mul_pipe_if slave (valid_i/ready_o/opa_i/opb_i/mode_i/tag_i,
//               valid_o/ready_i/res_o/tag_o)
//   Build option:
//     VP_MUL_FLUSH_EN : adds flush_i; when undefined the pipe drains only
//                       through the handshake.
//   Stages: S1 holds limb partial products + sign correction; S2..S(stage_p)
//   hold the adder tree, the last stage driving res_o. Bubbles keep their slot.
// -----------------------------------------------------------------------------
module mul_pipe
    import vp_mul_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int stage_p      = 3,
    parameter int limb_width_p = 23,
    parameter int tag_width_p  = 4
) (
    input  logic      clk_i,
    input  logic      rst_n,
`ifdef VP_MUL_FLUSH_EN
    input  logic      flush_i,
`endif
    mul_pipe_if.slave bus
);
    localparam int W    = data_width_p;
    localparam int LW   = limb_width_p;
    localparam int NL   = num_limbs(W, LW);
    localparam int PP_W = 2 * LW;
    localparam int RW   = 2 * W;
    localparam int NT   = MUL_MAX_LIMBS + 1;

    logic                   advance;
    logic                   flush;
    logic                   accept;
    logic [stage_p:1]       v_q;
    logic [tag_width_p-1:0] tag_q [1:stage_p];
    logic [PP_W-1:0]        pp_c  [NL][NL];
    logic [PP_W-1:0]        pp_q  [NL][NL];
    logic [W-1:0]           corr_c;
    logic [W-1:0]           corr_q;
    logic [RW-1:0]          term  [NT];
    logic [RW-1:0]          res_q;

`ifdef VP_MUL_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // No skid buffer: the whole pipe moves only when the output slot is free
    // or being drained, so ready_o is combinational from ready_i.
    assign advance     = ~v_q[stage_p] | bus.ready_i;
    assign bus.ready_o = advance & ~flush;
    assign accept      = bus.valid_i & bus.ready_o;

    mul_limb_pp #(
        .data_width_p (W),
        .limb_width_p (LW),
        .limbs_p      (NL)
    ) u_limb_pp (
        .opa_i  (bus.opa_i),
        .opb_i  (bus.opb_i),
        .mode_i (mul_mode_e'(bus.mode_i)),
        .pp_o   (pp_c),
        .corr_o (corr_c)
    );

    // Valid bits and tags travel in lockstep; flush wins over a stall.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 1; k <= stage_p; k++) tag_q[k] <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else if (advance) begin
            v_q      <= {v_q[stage_p-1:1], accept};
            tag_q[1] <= bus.tag_i;
            for (int k = 2; k <= stage_p; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    // S1: partial products and correction term.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NL; i++)
                for (int j = 0; j < NL; j++) pp_q[i][j] <= '0;
            corr_q <= '0;
        end else if (advance) begin
            pp_q   <= pp_c;
            corr_q <= corr_c;
        end
    end

    // Tree leaves: one weighted row sum per opa limb plus the correction.
    // Everything is truncated to 2W bits since only the product mod 2^(2W)
    // is kept.
    always_comb begin
        for (int i = 0; i < NT; i++) term[i] = '0;
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < NL; j++)
                term[i] = term[i] + (RW'(pp_q[i][j]) << ((i + j) * LW));
        term[NT-1] = {corr_q, {W{1'b0}}};
    end

    if (stage_p <= MUL_MIN_STAGES) begin : g_tree2
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n)       res_q <= '0;
            else if (advance) res_q <= (term[0] + term[1]) + (term[2] + term[3]);
        end
    end else if (stage_p < MUL_MAX_STAGES) begin : g_tree3
        logic [RW-1:0] s2_q [NT];
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < NT; i++) s2_q[i] <= '0;
                res_q <= '0;
            end else if (advance) begin
                s2_q  <= term;
                res_q <= (s2_q[0] + s2_q[1]) + (s2_q[2] + s2_q[3]);
            end
        end
    end else begin : g_tree4
        logic [RW-1:0] s2_q [NT];
        logic [RW-1:0] s3_q [2];
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < NT; i++) s2_q[i] <= '0;
                s3_q[0] <= '0;
                s3_q[1] <= '0;
                res_q   <= '0;
            end else if (advance) begin
                s2_q    <= term;
                s3_q[0] <= s2_q[0] + s2_q[1];
                s3_q[1] <= s2_q[2] + s2_q[3];
                res_q   <= s3_q[0] + s3_q[1];
            end
        end
    end

    assign bus.valid_o = v_q[stage_p];
    assign bus.res_o   = res_q;
    assign bus.tag_o   = tag_q[stage_p];

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, fully pipelined W×W→2W multiplier for the VXU lanes.
- Successor to the fixed 64-bit multiplier, with four generalisations:
  - configurable width and depth;
  - signed, unsigned and mixed-sign modes;
  - per-op tag passthrough;
  - valid/ready backpressure that stalls the whole pipe.
- Sits between the VXU issue stage and the modular-reduction unit. Its result feeds Barrett/Montgomery stages downstream.

Parameters:
- data_width_p, 64, operand width W; legal range 16..64.
- stage_p, 3, pipeline depth = cycles from accept to valid_o with no stall; legal 2..4.
- limb_width_p, 23, split width for DSP partial products; ceil(W/limb_width_p) limbs per operand, at most 3.
- tag_width_p, 4, width of the sideband tag carried alongside each op.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  input op valid.
- ready_o  out  1  pipe can accept an op this cycle.
- opa_i  in  W  multiplicand.
- opb_i  in  W  multiplier.
- mode_i  in  2  00 unsigned×unsigned, 01 signed×signed, 10 signed(a)×unsigned(b), 11 reserved (treated as 00).
- tag_i  in  tag_width_p  sideband tag, returned unchanged on tag_o.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- res_o  out  2W  full product, two's complement for signed modes.
- tag_o  out  tag_width_p  tag of the op currently on res_o.

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0, valid_o 0, res_o 0, tag_o 0. Reset mid-operation discards all in-flight ops; nothing is emitted after release until new ops are accepted.
- Handshake:
  - An input is accepted when valid_i && ready_o.
  - An output is consumed when valid_o && ready_i.
  - Once valid_o is asserted, res_o and tag_o hold stable until consumed.
- Global stall:
  - advance = ~valid_o | ready_i.
  - ready_o = advance; it is combinational from ready_i, so there is no skid buffer.
  - When advance=0, every stage register, including valid bits, holds its value.
- Latency and throughput: exactly stage_p cycles from accept to valid_o when never stalled; 1 op/cycle sustained.
- Bubbles are not collapsed: an invalid stage still occupies its slot.
- Results are in order; tags travel in lockstep with data.
- Arithmetic:
  - Sign-extend each operand to W+1 bits per mode (opa_i signed when mode is 01 or 10; opb_i signed only for 01).
  - Form the (2W+2)-bit product and truncate to 2W. The result is bit-exact to the mathematical product modulo 2^(2W).
- Stage mapping:
  - S1 registers limb partial products. Unsigned limbs; the sign correction is a separate term, registered in S1.
  - S2..S(stage_p) register a balanced adder tree; the final stage drives res_o.
  - For stage_p=2, the whole tree sits in S2.
- Simultaneous events: consume and accept in the same cycle are both legal; the pipe advances one slot.
- Reserved mode 11 is accepted and computes as 00; no error flag.
- valid_i held high while ready_o=0: the op is not accepted; the producer must hold its operands stable.

Optional Feature:
- Macro: VP_MUL_FLUSH_EN.
- When defined, an input port flush_i (1 bit, synchronous) is present:
  - flush_i=1 clears all stage valid bits and valid_o on the next edge, regardless of advance.
  - A valid_i presented in the same cycle is dropped.
  - ready_o is forced to 0 while flush_i=1.
  - Data registers may keep stale values.
- When undefined, the port does not exist and the pipe drains only via the handshake.

Decomposition:
- Package vp_mul_pkg holds:
  - typedef enum logic [1:0] mul_mode_e {MUL_UU, MUL_SS, MUL_SU, MUL_RSV};
  - localparams for maximum limb count (3) and minimum/maximum stage_p;
  - function num_limbs(W, limb_width_p).
- One sub-module, mul_limb_pp: combinational limb split + partial-product generation + sign-correction term, instantiated once in front of S1.
- The pipeline registers, stall logic and adder tree stay in mul_pipe.

Test Plan:
- Mode 00, opa=opb=0xFFFF_FFFF_FFFF_FFFF, ready_i=1 → after exactly 3 cycles valid_o=1, res_o=0xFFFFFFFFFFFFFFFE_0000000000000001.
- Mode 01, opa=0xFFFF_FFFF_FFFF_FFFF (−1), opb=2 → res_o=0xFFFF…FFFE (all 128 bits); mode 10 with opa=−1, opb=0xFFFF_FFFF_FFFF_FFFF → res_o=0xFFFFFFFFFFFFFFFF_0000000000000001.
- Back-to-back 8 ops, tags 0..7, ready_i=1 → 8 consecutive valid_o cycles starting at cycle 3, tags in order 0..7, products match the model.
- ready_i=0 for 5 cycles with the pipe full → ready_o=0, res_o/tag_o stable. On release, ops drain in order with none lost or duplicated.
- Assert rst_n=0 mid-stream with 2 ops in flight → valid_o=0, res_o=0 immediately; after release, no output until a new accept.
- With VP_MUL_FLUSH_EN: flush_i pulse with 3 ops in flight and valid_i=1 → valid_o=0 next cycle, the concurrent op is dropped, and the next accepted op emerges stage_p cycles later.
